rf_cmd_sequencer: RTL and testbench
===================================

Name: rf_cmd_sequencer

Overview:
- Upstream command source for the 32x32 register-file datapath.
- Buffers a short program of 8-bit datapath commands (opcode [2:0], operand [7:3]) loaded over a valid/ready write port.
- On start, replays the program one command per cycle, optionally for several passes, with cmd_valid gating the datapath enable.
- Lets the datapath be exercised at full rate from slow pin-level loading.

Parameters:
- DEPTH, 16, number of command entries in the program buffer (power of two, 2..64).
- AW, $clog2(DEPTH), buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_data  in  8  command byte to append to the program.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  byte is accepted this cycle when wr_valid and wr_ready are both high.
- clear  in  1  empties the program buffer (IDLE only).
- start  in  1  begin replay (IDLE only).
- loop_cnt  in  8  extra passes, sampled at start; 0 gives a single pass.
- cmd_out  out  8  command to datapath.
- cmd_valid  out  1  cmd_out is valid; datapath executes only when high.
- cmd_ready  in  1  datapath accepts cmd_out this cycle (stall when low).
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse after the final command is accepted.
- count  out  AW+1  number of bytes stored.
- sig  out  8  command signature (see Optional Feature).

Behaviour:
- Reset, synchronous on posedge clk while rst=1:
  - state=IDLE; wptr, rptr, count, pass counter = 0.
  - cmd_out=0, cmd_valid=0, done=0, sig=0.
  - Buffer contents are not reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - wr_ready = (count != DEPTH) && !start && !clear, driven combinationally.
  - On accept, mem[wptr]<=wr_data, wptr++, count++.
  - When full, wr_ready=0 and writes are dropped.
- clear in IDLE: wptr and count go to 0 next cycle. clear has priority over start and write.
- start in IDLE with count>0:
  - Next state is RUN; latch pass counter to loop_cnt.
  - cmd_out<=mem[0], cmd_valid<=1, rptr<=1 (next index).
  - First command is visible the cycle after start.
- start with count==0: ignored and stays in IDLE.
- start, clear or wr_valid while not in IDLE: ignored; wr_ready=0.
- RUN:
  - An accept is cmd_valid && cmd_ready at a clock edge.
  - cmd_ready low: cmd_out and cmd_valid hold stable.
  - On accept of a non-final entry: cmd_out<=mem[rptr], advance rptr. Throughput is 1 command/cycle.
  - On accept of entry count-1 with pass counter > 0: decrement the pass counter and restart at mem[0] with no bubble.
  - On accept of entry count-1 with pass counter == 0: cmd_valid<=0, cmd_out<=0, state<=DONE.
  - Total accepted commands = count*(loop_cnt+1).
- DONE: done=1 for exactly one cycle, then IDLE. The program is retained, so start replays it.
- busy = (state==RUN).
- count=DEPTH is legal; rptr wraps from DEPTH-1 to 0.
- rst mid-RUN: the next cycle has cmd_valid=0 and count=0, and no further command is issued.

Optional Feature:
- Macro: RF_CMD_SEQ_SIGNATURE_EN.
- Defined:
  - sig is cleared when start is accepted.
  - On every accepted command: sig <= {sig[6:0],sig[7]} ^ cmd_out.
  - sig holds in IDLE and DONE.
- Undefined: sig tied to 8'h00 and no signature logic is built. The port list is identical in both cases.

Test Plan:
- Reset, then write 8'h0B, 8'h11, 8'h05 with cmd_ready=1, then start, loop_cnt=0 -> cmd_out 0B,11,05 on consecutive cycles with cmd_valid=1; done pulses 1 cycle later; count stays 3.
- Same program with loop_cnt=2 -> 9 accepted commands repeating 0B,11,05 with no gaps; exactly one done pulse.
- Hold cmd_ready=0 for 3 cycles while 8'h11 is presented -> cmd_out holds 11 and cmd_valid holds 1; the sequence resumes unchanged.
- Write 17 bytes with DEPTH=16 -> wr_ready=0 after the 16th; count=16; replay issues exactly 16 commands with correct wrap.
- start with count=0 -> stays IDLE with busy=0. Assert clear and start together with count=3 -> count=0 and no run.
- Assert rst during the second command of a run -> cmd_valid=0 and count=0 next cycle. With RF_CMD_SEQ_SIGNATURE_EN and program 01,02 -> sig=8'h00 after reset, and sig=8'h00 after the run ({00}^01=01, rotated 02 ^02=00).

Source files
------------

// File: rtl/rf_cmd_sequencer.sv
// rf_cmd_sequencer: buffers a command program and replays it to the datapath; RF_CMD_SEQ_SIGNATURE_EN adds the rotate-XOR sig
module rf_cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          clear,
  input  logic          start,
  input  logic [7:0]    loop_cnt,
  output logic [7:0]    cmd_out,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [7:0]    sig
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0] pass;
  logic idle, wr_acc, go, acc, last;
  assign idle = state == IDLE;
  assign wr_ready = idle && count != (AW+1)'(DEPTH) && !start && !clear;
  assign wr_acc = wr_valid && wr_ready;
  assign go = idle && start && !clear && count != '0;
  assign acc = state == RUN && cmd_valid && cmd_ready;
  assign last = rptr == count[AW-1:0];
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (wr_acc) mem[wptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      pass <= '0;
      cmd_out <= '0;
      cmd_valid <= 1'b0;
    end else begin
      if (idle && clear) begin
        wptr <= '0;
        count <= '0;
      end else if (wr_acc) begin
        wptr <= wptr + AW'(1);
        count <= count + (AW+1)'(1);
      end
      if (go) begin
        state <= RUN;
        pass <= loop_cnt;
        cmd_out <= mem[0];
        cmd_valid <= 1'b1;
        rptr <= AW'(1);
      end else if (acc) begin
        if (!last) begin
          cmd_out <= mem[rptr];
          rptr <= rptr + AW'(1);
        end else if (pass != 8'd0) begin
          pass <= pass - 8'd1;
          cmd_out <= mem[0];
          rptr <= AW'(1);
        end else begin
          cmd_valid <= 1'b0;
          cmd_out <= '0;
          state <= DONE;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
`ifdef RF_CMD_SEQ_SIGNATURE_EN
  always_ff @(posedge clk)
    if (rst || go) sig <= '0;
    else if (acc) sig <= {sig[6:0], sig[7]} ^ cmd_out;
`else
  assign sig = 8'h00;
`endif
endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// tb_rf_cmd_sequencer: randomized directed bench for rf_cmd_sequencer against a queue-based program model
module tb_rf_cmd_sequencer;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] wr_data = '0, loop_cnt = '0, cmd_out, sig;
  logic wr_valid = 1'b0, wr_ready, clear = 1'b0, start = 1'b0;
  logic cmd_valid, cmd_ready = 1'b0, busy, done;
  logic [AW:0] count;
  int checks = 0, errors = 0;
  logic [7:0] prog[$];
  logic [7:0] m_sig = '0;

  rf_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .clear(clear), .start(start), .loop_cnt(loop_cnt), .cmd_out(cmd_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .count(count), .sig(sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_sig();
`ifdef RF_CMD_SEQ_SIGNATURE_EN
    return m_sig;
`else
    return 8'h00;
`endif
  endfunction

  task automatic wr(input logic [7:0] b);
    logic exp_rdy;
    exp_rdy = prog.size() < DEPTH;
    wr_data = b;
    wr_valid = 1'b1;
    #1;
    chk("wr_ready", wr_ready, exp_rdy);
    tick();
    wr_valid = 1'b0;
    if (exp_rdy) prog.push_back(b);
    chk("count_wr", count, prog.size());
  endtask

  task automatic clr();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    chk("count_clr", count, 0);
  endtask

  task automatic run(input logic [7:0] loops, input int stall_pct);
    logic [7:0] exp[$];
    int idx, budget;
    idx = 0;
    budget = 0;
    for (int p = 0; p <= int'(loops); p++)
      foreach (prog[i]) exp.push_back(prog[i]);
    loop_cnt = loops;
    start = 1'b1;
    #1;
    chk("wr_ready_start", wr_ready, 0);
    tick();
    start = 1'b0;
    m_sig = '0;
    while (idx < exp.size() && budget < 2000) begin
      cmd_ready = $urandom_range(99) >= stall_pct;
      wr_valid = $urandom_range(1);
      wr_data = $urandom;
      start = $urandom_range(1);
      clear = $urandom_range(1);
      loop_cnt = $urandom;
      #1;
      chk("cmd_valid_run", cmd_valid, 1);
      chk("cmd_out_run", cmd_out, exp[idx]);
      chk("busy_run", busy, 1);
      chk("wr_ready_run", wr_ready, 0);
      chk("sig_run", sig, exp_sig());
      chk("count_run", count, prog.size());
      tick();
      if (cmd_ready) begin
        m_sig = {m_sig[6:0], m_sig[7]} ^ exp[idx];
        idx++;
      end
      budget++;
    end
    wr_valid = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    chk("run_budget", idx, exp.size());
    chk("done_pulse", done, 1);
    chk("cmd_valid_done", cmd_valid, 0);
    chk("cmd_out_done", cmd_out, 0);
    chk("busy_done", busy, 0);
    chk("sig_done", sig, exp_sig());
    tick();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("count_kept", count, prog.size());
    chk("sig_hold", sig, exp_sig());
    cmd_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_count", count, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_out", cmd_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sig", sig, 0);
    rst = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    tick();
    wr(8'h0B); wr(8'h11); wr(8'h05);
    run(8'd0, 0);
    run(8'd2, 0);
    run(8'd1, 50);
    clear = 1'b1;
    start = 1'b1;
    #1;
    chk("wr_ready_clr_start", wr_ready, 0);
    tick();
    clear = 1'b0;
    start = 1'b0;
    prog.delete();
    chk("count_clr_start", count, 0);
    chk("busy_clr_start", busy, 0);
    chk("cmd_valid_clr_start", cmd_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_empty_start", busy, 0);
    chk("cmd_valid_empty_start", cmd_valid, 0);
    tick();
    chk("busy_empty_after", busy, 0);
    for (int i = 0; i < 17; i++) wr(8'($urandom));
    chk("count_full", count, DEPTH);
    run(8'd1, 25);
    for (int it = 0; it < 5; it++) begin
      clr();
      for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) wr(8'($urandom));
      run(8'($urandom_range(0, 3)), 30);
    end
    clr();
    wr(8'h01); wr(8'h02);
    run(8'd0, 0);
    chk("sig_0102", sig, 8'h00);
    clr();
    wr(8'h0B); wr(8'h11); wr(8'h05);
    loop_cnt = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cmd_ready = 1'b1;
    chk("mid_first", cmd_out, 8'h0B);
    tick();
    chk("mid_second", cmd_out, 8'h11);
    rst = 1'b1;
    tick();
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sig", sig, 0);
    rst = 1'b0;
    prog.delete();
    tick();
    chk("post_rst_cmd_valid", cmd_valid, 0);
    chk("post_rst_done", done, 0);
    cmd_ready = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
